// File: rtl/bpsk_frame_source_pkg.sv
// ============================================================================
// Module : bpsk_frame_source_pkg
// Brief  : Shared state encodings and constants for the BPSK frame source.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package bpsk_frame_source_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_SYNC     = 2'd2,
    ST_PAYLOAD  = 2'd3
  } state_t;

  localparam logic [15:0] c_sync_word_default = 16'h1ACF;
  localparam logic [6:0]  c_prbs_seed         = 7'h7F;
  localparam int          c_clk_cnt_w         = 16;
  localparam int          c_bit_cnt_w         = 12;

  // Index of the last bit of the given section.
  function automatic logic [c_bit_cnt_w-1:0] section_last(
    input state_t                 st,
    input logic [c_bit_cnt_w-1:0] pre_last,
    input logic [c_bit_cnt_w-1:0] pay_last
  );
    case (st)
      ST_PREAMBLE: return pre_last;
      ST_SYNC:     return 12'd15;
      default:     return pay_last;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/prbs7_gen.sv
// ============================================================================
// Module : prbs7_gen
// Brief  : PRBS-7 (x^7+x^6+1) source with reseed and advance controls.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module prbs7_gen
  import bpsk_frame_source_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic advance,
  output logic bit_out
);

  logic [6:0] r_lfsr;

  // Reseed wins over advance so a frame restart never sees a stale state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_lfsr <= c_prbs_seed;
    end else if (load) begin
      r_lfsr <= c_prbs_seed;
    end else if (advance) begin
      r_lfsr <= {r_lfsr[5:0], r_lfsr[6] ^ r_lfsr[5]};
    end
  end

  assign bit_out = r_lfsr[6];

endmodule

`default_nettype wire

// File: rtl/bpsk_frame_source.sv
// ============================================================================
// Module : bpsk_frame_source
// Brief  : Launches a preamble / sync / PRBS-7 payload bit stream per start.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bpsk_frame_source
  import bpsk_frame_source_pkg::*;
#(
  parameter int unsigned  CLK_PER_BIT   = 4,
  parameter int unsigned  PREAMBLE_BITS = 8,
  parameter logic [15:0]  SYNC_WORD     = c_sync_word_default,
  parameter int unsigned  PAYLOAD_BITS  = 32
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  output logic bit_out,
  output logic symbol_tick,
  output logic busy,
  output logic frame_done
);

  localparam logic [c_clk_cnt_w-1:0] c_cpb_last = 16'(CLK_PER_BIT - 1);
  localparam logic [c_bit_cnt_w-1:0] c_pre_last = 12'(PREAMBLE_BITS - 1);
  localparam logic [c_bit_cnt_w-1:0] c_pay_last = 12'(PAYLOAD_BITS - 1);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [c_clk_cnt_w-1:0]  r_clk_cnt;
  logic [c_clk_cnt_w-1:0]  w_clk_nxt;
  logic [c_bit_cnt_w-1:0]  r_bit_cnt;
  logic [c_bit_cnt_w-1:0]  w_bit_nxt;
  logic                    r_pending;
  logic                    w_pend_nxt;
  logic                    r_frame_done;
  logic                    w_done_nxt;
  logic                    w_prbs_load;
  logic                    w_prbs_adv;
  logic                    w_prbs_bit;
  logic                    w_wrap;
  logic                    w_sect_end;
  logic [3:0]              w_sync_idx;
  logic                    w_bit;

  prbs7_gen u_prbs (
    .clock   (clock),
    .reset   (reset),
    .load    (w_prbs_load),
    .advance (w_prbs_adv),
    .bit_out (w_prbs_bit)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_clk_cnt    <= '0;
      r_bit_cnt    <= '0;
      r_pending    <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_clk_cnt    <= w_clk_nxt;
      r_bit_cnt    <= w_bit_nxt;
      r_pending    <= w_pend_nxt;
      r_frame_done <= w_done_nxt;
    end
  end

  assign w_wrap     = (r_clk_cnt == c_cpb_last);
  assign w_sect_end = w_wrap && (r_bit_cnt == section_last(r_state, c_pre_last, c_pay_last));

  always_comb begin
    w_state_nxt = r_state;
    w_clk_nxt   = r_clk_cnt;
    w_bit_nxt   = r_bit_cnt;
    w_pend_nxt  = r_pending;
    w_done_nxt  = 1'b0;
    w_prbs_load = 1'b0;
    w_prbs_adv  = 1'b0;
    if (r_state == ST_IDLE) begin
      w_pend_nxt = 1'b0;
      if (start) begin
        w_state_nxt = ST_PREAMBLE;
        w_clk_nxt   = '0;
        w_bit_nxt   = '0;
        w_prbs_load = 1'b1;
      end
    end else begin
      if (start) w_pend_nxt = 1'b1;
      if (!w_wrap) begin
        w_clk_nxt = r_clk_cnt + 16'd1;
      end else begin
        w_clk_nxt  = '0;
        w_prbs_adv = (r_state == ST_PAYLOAD);
        if (!w_sect_end) begin
          w_bit_nxt = r_bit_cnt + 12'd1;
        end else begin
          w_bit_nxt = '0;
          case (r_state)
            ST_PREAMBLE: w_state_nxt = ST_SYNC;
            ST_SYNC:     w_state_nxt = ST_PAYLOAD;
            default: begin
              // A start landing on the final clock counts as pending too.
              w_done_nxt = 1'b1;
              if (r_pending || start) begin
                w_state_nxt = ST_PREAMBLE;
                w_prbs_load = 1'b1;
                w_pend_nxt  = 1'b0;
              end else begin
                w_state_nxt = ST_IDLE;
              end
            end
          endcase
        end
      end
    end
  end

  assign w_sync_idx = 4'd15 - r_bit_cnt[3:0];

  always_comb begin
    w_bit = 1'b0;
    case (r_state)
      ST_PREAMBLE: w_bit = ~r_bit_cnt[0];
      ST_SYNC:     w_bit = SYNC_WORD[w_sync_idx];
      ST_PAYLOAD:  w_bit = w_prbs_bit;
      default:     w_bit = 1'b0;
    endcase
  end

  assign bit_out     = w_bit;
  assign busy        = (r_state != ST_IDLE);
  assign symbol_tick = busy && (r_clk_cnt == '0);
  assign frame_done  = r_frame_done;

endmodule

`default_nettype wire

// File: tb/tb_bpsk_frame_source.sv
// ============================================================================
// Module : tb_bpsk_frame_source
// Brief  : Scoreboard bench for bpsk_frame_source with a frame-level model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bpsk_frame_source;

  localparam int CPB   = 4;
  localparam int PRE   = 8;
  localparam int PAY   = 32;
  localparam int NBITS = PRE + 16 + PAY;
  localparam int LEN   = NBITS * CPB;

  typedef struct { int cyc; logic b; } tick_t;
  typedef struct { int s; int e; } span_t;

  logic clock = 1'b0, reset = 1'b1, start = 1'b0, start_b = 1'b0;
  logic bit_out, symbol_tick, busy, frame_done;
  logic bit_b, tick_b, busy_b, done_b;

  bpsk_frame_source dut (
    .clock(clock), .reset(reset), .start(start),
    .bit_out(bit_out), .symbol_tick(symbol_tick), .busy(busy), .frame_done(frame_done)
  );

  bpsk_frame_source #(
    .CLK_PER_BIT(2), .PREAMBLE_BITS(8), .SYNC_WORD(16'h1ACF), .PAYLOAD_BITS(1)
  ) dut_b (
    .clock(clock), .reset(reset), .start(start_b),
    .bit_out(bit_b), .symbol_tick(tick_b), .busy(busy_b), .frame_done(done_b)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_tests = 0, n_fail = 0;
  logic prbs_ref [0:4095];
  tick_t q_tick[$];
  span_t q_busy[$];
  int    q_done[$];
  int    m_f_last = -1000, m_d_last = -1000;

  task automatic chk(string nm, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  // Expected k-th bit of a frame, straight from the frame layout rules.
  function automatic logic ref_bit(int k, int pre);
    logic [15:0] sw;
    sw = 16'h1ACF;
    if (k < pre) return (k % 2 == 0) ? 1'b1 : 1'b0;
    else if (k < pre + 16) return sw[15 - (k - pre)];
    else return prbs_ref[k - pre - 16];
  endfunction

  // Start pulse seen in cycle s: idle -> frame next cycle; busy -> queued behind latest frame.
  task automatic schedule_start(int s);
    int f;
    if (s >= m_d_last) f = s + 1;
    else if (s < m_f_last) return;
    else f = m_d_last;
    m_f_last = f;
    m_d_last = f + LEN;
    q_busy.push_back(span_t'{f, f + LEN - 1});
    for (int k = 0; k < NBITS; k++) q_tick.push_back(tick_t'{f + k * CPB, ref_bit(k, PRE)});
    q_done.push_back(f + LEN);
  endtask

  task automatic step(int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic pulse();
    start = 1'b1;
    schedule_start(cyc);
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle();
    while (cyc <= m_d_last + 2) step();
  endtask

  logic  hold_b = 1'b0;
  tick_t mt;
  always @(negedge clock) begin
    if (!reset) begin
      logic exp_busy, exp_tick, exp_done;
      while (q_busy.size() > 0 && q_busy[0].e < cyc) void'(q_busy.pop_front());
      exp_busy = (q_busy.size() > 0) && (q_busy[0].s <= cyc);
      chk("busy", busy, exp_busy);
      exp_tick = (q_tick.size() > 0) && (q_tick[0].cyc == cyc);
      chk("symbol_tick", symbol_tick, exp_tick);
      if (exp_tick) begin
        mt = q_tick.pop_front();
        hold_b = mt.b;
        chk("bit_out", bit_out, mt.b);
      end else if (exp_busy) begin
        chk("bit_hold", bit_out, hold_b);
      end else begin
        chk("idle_bit", bit_out, 0);
      end
      exp_done = (q_done.size() > 0) && (q_done[0] == cyc);
      chk("frame_done", frame_done, exp_done);
      if (exp_done) void'(q_done.pop_front());
    end
  end

  initial begin
    int nt;
    for (int i = 0; i < 7; i++) prbs_ref[i] = 1'b1;
    for (int i = 7; i < 4096; i++) prbs_ref[i] = prbs_ref[i-7] ^ prbs_ref[i-6];

    step(3);
    chk("rst_busy", busy, 0);
    chk("rst_bit", bit_out, 0);
    chk("rst_tick", symbol_tick, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_busy_b", busy_b, 0);
    @(negedge clock);
    reset = 1'b0;
    step(2);

    // single frame
    pulse();
    wait_idle();

    // three pulses inside one frame collapse into one follow-on frame
    pulse();
    step(20); pulse();
    step(50); pulse();
    step(30); pulse();
    wait_idle();

    // start in the frame_done cycle
    pulse();
    for (int i = 0; i < LEN + 10; i++) begin
      step();
      if (frame_done) break;
    end
    pulse();
    wait_idle();

    // start on the final busy clock of a frame
    pulse();
    while (cyc < m_d_last - 1) step();
    pulse();
    wait_idle();

    // asynchronous reset at clock 100 of a frame
    pulse();
    step(99);
    reset = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_bit", bit_out, 0);
    chk("arst_tick", symbol_tick, 0);
    chk("arst_done", frame_done, 0);
    q_tick.delete(); q_busy.delete(); q_done.delete();
    m_f_last = -1000; m_d_last = -1000;
    step(2);
    @(negedge clock);
    reset = 1'b0;
    step(3);
    pulse();
    wait_idle();

    // randomized start traffic
    for (int it = 0; it < 8; it++) begin
      step($urandom_range(0, 300));
      nt = $urandom_range(1, 3);
      for (int j = 0; j < nt; j++) begin
        pulse();
        step($urandom_range(0, 120));
      end
    end
    wait_idle();
    chk("ticks_left", q_tick.size(), 0);
    chk("done_left", q_done.size(), 0);

    // minimum bit period, single payload bit
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    nt = 0;
    for (int off = 1; off <= 55; off++) begin
      @(negedge clock);
      chk("b_busy", busy_b, (off <= 50) ? 1 : 0);
      chk("b_tick", tick_b, (off <= 50 && (off - 1) % 2 == 0) ? 1 : 0);
      if (tick_b) begin
        chk("b_bit", bit_b, ref_bit(nt, 8));
        nt++;
      end
      chk("b_done", done_b, (off == 51) ? 1 : 0);
    end
    chk("b_tick_count", nt, 25);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
